alu_arbiter: RTL and testbench

Shares the single combinational `alu` datapath between two requesters (port 0: execute stage, port 1: address/auxiliary unit). Each requester uses a valid/ready handshake. Round-robin arbitration picks one request, which the block registers and drives onto the ALU. The block returns the result and flags through a per-port response handshake and maintains the architectural NZCV flag register. It sits between the requesters and the `alu` instance; the ALU stays purely combinational.

---
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. One op is in flight at a time: IDLE accepts, EXEC evaluates,
// RESP holds the registered result until the owning port takes it.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_ctrl_0,
    input  logic [3:0]  req_ctrl_1,
    input  logic        req_setf_0,
    input  logic        req_setf_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [31:0] alu_src_a,
    output logic [31:0] alu_src_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags_q,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic        owner;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_ctrl;
    logic        op_setf;
    logic        grant_vld;
    logic        grant;
    logic        accept;
    logic        rsp_take;

    // Grant: a lone requester always wins; on a tie the port that did not win last time wins
    always_comb begin
        grant_vld = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1)
            grant = ~last_grant;
        else
            grant = req_valid_1;
    end

    assign accept   = (state == IDLE) && grant_vld;
    assign rsp_take = owner ? rsp_ready_1 : rsp_ready_0;

    // ALU inputs come only from the operand registers so requester changes never reach the ALU
    assign alu_src_a   = op_a;
    assign alu_src_b   = op_b;
    assign alu_control = op_ctrl;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs; ready is gated by reset so nothing looks accepted while held in reset
    always_comb begin
        req_ready_0 = reset_n && (state == IDLE) && grant_vld && !grant;
        req_ready_1 = reset_n && (state == IDLE) && grant_vld &&  grant;
        rsp_valid_0 = (state == RESP) && !owner;
        rsp_valid_1 = (state == RESP) &&  owner;
        busy        = (state != IDLE);
    end

    // Capture the granted request; last_grant starts at 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            op_setf    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_a       <= grant ? req_a_1    : req_a_0;
            op_b       <= grant ? req_b_1    : req_b_0;
            op_ctrl    <= grant ? req_ctrl_1 : req_ctrl_0;
            op_setf    <= grant ? req_setf_1 : req_setf_0;
            owner      <= grant;
            last_grant <= grant;
        end
    end

    // Register the ALU outputs at the end of EXEC; NZCV updates only for setf ops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            flags_q    <= '0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            if (op_setf)
                flags_q <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference (one op in flight, 2-cycle latency,
// round-robin grant) and a behavioural ALU that the bench itself provides.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid_0 = 0, req_valid_1 = 0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0 = 0, req_a_1 = 0, req_b_0 = 0, req_b_1 = 0;
    logic [3:0]  req_ctrl_0 = 0, req_ctrl_1 = 0;
    logic        req_setf_0 = 0, req_setf_1 = 0;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0 = 0, rsp_ready_1 = 0;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_src_a, alu_src_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags_q;
    logic        busy;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .req_setf_0(req_setf_0), .req_setf_1(req_setf_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .flags_q(flags_q), .busy(busy)
    );

    // Behavioural ALU: returns {result, N, Z, C, V}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, ov;
        s = '0; r = a; cy = 1'b0; ov = 1'b0;
        case (c)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r, r[31], (r == 32'd0), cy, ov};
    endfunction

    always_comb {alu_result, alu_flags} = alu_fn(alu_src_a, alu_src_b, alu_control);

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference state: at most one op in flight, age = cycles since acceptance
    bit          have_op = 0;
    int          age = 0;
    bit          own = 0;
    bit          last = 1;
    logic [31:0] ref_a = 0, ref_b = 0;
    logic [3:0]  ref_c = 0;
    bit          ref_s = 0;
    logic [31:0] ref_res = 0;
    logic [3:0]  ref_rf = 0, ref_fq = 0;
    bit          g_q[$];
    int          c_q[$];

    task automatic model_reset();
        have_op = 0; age = 0; own = 0; last = 1;
        ref_a = 0; ref_b = 0; ref_c = 0; ref_s = 0;
        ref_res = 0; ref_rf = 0; ref_fq = 0;
    endtask

    // Compare visible outputs, then advance the reference across the coming edge
    task automatic model_cycle();
        bit g_en, g;
        logic [35:0] r;
        check("busy", busy, have_op);
        check("alu_a", alu_src_a, ref_a);
        check("alu_b", alu_src_b, ref_b);
        check("alu_c", alu_control, ref_c);
        check("flags_q", flags_q, ref_fq);
        check("rsp_result", rsp_result, ref_res);
        check("rsp_flags", rsp_flags, ref_rf);
        check("rsp_v0", rsp_valid_0, have_op && age >= 2 && !own);
        check("rsp_v1", rsp_valid_1, have_op && age >= 2 && own);
        g_en = !have_op && (req_valid_0 || req_valid_1);
        g = (req_valid_0 && req_valid_1) ? !last : req_valid_1;
        check("req_rdy0", req_ready_0, g_en && !g);
        check("req_rdy1", req_ready_1, g_en && g);
        if (have_op) begin
            if (age == 1) begin
                r = alu_fn(ref_a, ref_b, ref_c);
                ref_res = r[35:4];
                ref_rf = r[3:0];
                if (ref_s) ref_fq = r[3:0];
                age = 2;
            end else if (own ? rsp_ready_1 : rsp_ready_0) begin
                have_op = 0;
            end
        end else if (g_en) begin
            have_op = 1; age = 1; own = g; last = g;
            ref_a = g ? req_a_1 : req_a_0;
            ref_b = g ? req_b_1 : req_b_0;
            ref_c = g ? req_ctrl_1 : req_ctrl_0;
            ref_s = g ? req_setf_1 : req_setf_0;
            g_q.push_back(g);
            c_q.push_back(cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic look();
        @(negedge clk);
        model_cycle();
        cyc++;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 7));
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic randomize_inputs();
        req_valid_0 = ($urandom_range(0, 9) < 6);
        req_valid_1 = ($urandom_range(0, 9) < 6);
        req_a_0 = rnd_op(); req_b_0 = rnd_op();
        req_a_1 = rnd_op(); req_b_1 = rnd_op();
        req_ctrl_0 = 4'($urandom_range(0, 5));
        req_ctrl_1 = 4'($urandom_range(0, 5));
        req_setf_0 = 1'($urandom_range(0, 1));
        req_setf_1 = 1'($urandom_range(0, 1));
        rsp_ready_0 = 1'($urandom_range(0, 1));
        rsp_ready_1 = 1'($urandom_range(0, 1));
    endtask

    // Assert reset mid-cycle, check the immediate effect, hold it across one edge
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rv0", rsp_valid_0, 0);
        check("rst_rv1", rsp_valid_1, 0);
        check("rst_rdy0", req_ready_0, 0);
        check("rst_rdy1", req_ready_1, 0);
        check("rst_flags_q", flags_q, 0);
        check("rst_alu_a", alu_src_a, 0);
        check("rst_result", rsp_result, 0);
        model_reset();
        @(posedge clk);
    endtask

    logic [3:0] ef;
    int start;

    initial begin
        do_reset();

        // Single op latency, port 0: 5 + 7 with setf
        tick(); req_valid_0 = 1; req_valid_1 = 0; req_a_0 = 5; req_b_0 = 7;
        req_ctrl_0 = 0; req_setf_0 = 1; rsp_ready_0 = 1; rsp_ready_1 = 0; look();
        check("t1_rdy0", req_ready_0, 1);
        tick(); req_valid_0 = 0; req_a_0 = 0; look();
        check("t1_src_a", alu_src_a, 5);
        check("t1_src_b", alu_src_b, 7);
        ef = alu_flags;
        tick(); look();
        check("t1_rv0", rsp_valid_0, 1);
        check("t1_rv1", rsp_valid_1, 0);
        check("t1_res", rsp_result, 12);
        check("t1_fq", flags_q, ef);
        tick(); look();

        // Flag write enable, port 1: 5 - 5 without then with setf
        for (int s = 0; s < 2; s++) begin
            tick(); req_valid_1 = 1; req_a_1 = 5; req_b_1 = 5; req_ctrl_1 = 1;
            req_setf_1 = 1'(s); rsp_ready_1 = 1; look();
            tick(); req_valid_1 = 0; look();
            tick(); look();
            check("t2_zero", rsp_flags[2], 1);
            if (s == 0) check("t2_fq_hold", flags_q, ef);
            else        check("t2_fq_z", flags_q[2], 1);
            tick(); look();
        end

        // Reset while an op is in EXEC, then a port-0 op right after release
        tick(); req_valid_0 = 1; req_a_0 = 9; req_b_0 = 1; req_ctrl_0 = 1; req_setf_0 = 1; look();
        do_reset();
        tick(); req_valid_0 = 1; req_valid_1 = 0; req_a_0 = 1; req_b_0 = 2;
        req_ctrl_0 = 0; rsp_ready_0 = 1; look();
        check("t3_rdy0", req_ready_0, 1);
        tick(); req_valid_0 = 0; look();
        tick(); look();
        tick(); look();

        // Round-robin under continuous requests from both ports
        start = g_q.size();
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        repeat (13) begin
            tick(); req_valid_0 = 1; req_valid_1 = 1;
            req_a_0 = rnd_op(); req_b_0 = rnd_op(); req_a_1 = rnd_op(); req_b_1 = rnd_op();
            req_ctrl_0 = 4'($urandom_range(0, 5)); req_ctrl_1 = 4'($urandom_range(0, 5));
            look();
        end
        tick(); req_valid_0 = 0; req_valid_1 = 0; look();
        tick(); look();
        tick(); look();
        check("t4_count", 32'(g_q.size() - start >= 4), 1);
        for (int i = start + 1; i < g_q.size(); i++) begin
            check("t4_alt", g_q[i], !g_q[i-1]);
            check("t4_gap", c_q[i] - c_q[i-1], 3);
        end

        // Response backpressure on port 0 while port 1 waits
        tick(); req_valid_0 = 1; req_valid_1 = 0; req_a_0 = 40; req_b_0 = 2;
        req_ctrl_0 = 1; rsp_ready_0 = 0; look();
        tick(); req_valid_0 = 0; req_valid_1 = 1; req_a_1 = 7; req_b_1 = 8; req_ctrl_1 = 0; look();
        repeat (5) begin
            tick(); look();
            check("t5_rv0", rsp_valid_0, 1);
            check("t5_rdy1", req_ready_1, 0);
            check("t5_res", rsp_result, 38);
        end
        tick(); rsp_ready_0 = 1; look();
        tick(); look();
        check("t5_grant1", req_ready_1, 1);
        tick(); req_valid_1 = 0; look();
        tick(); look();
        tick(); look();

        // Input isolation: operand changes after the handshake, non-owner ready toggling
        tick(); req_valid_0 = 1; req_a_0 = 3; req_b_0 = 0; req_ctrl_0 = 0;
        req_setf_0 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0; look();
        tick(); req_a_0 = 99; rsp_ready_1 = 1; look();
        tick(); rsp_ready_1 = 0; look();
        check("t6_res", rsp_result, 3);
        tick(); rsp_ready_1 = 1; look();
        check("t6_held", rsp_valid_0, 1);
        tick(); rsp_ready_0 = 1; look();
        repeat (6) begin tick(); req_valid_0 = 0; look(); end

        // Random traffic with occasional resets
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            tick(); randomize_inputs(); look();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
